// File: rtl/cpu_pkg.sv
// cpu_pkg: default sizing shared by the decode-stage blocks.
//   CPU_NREG / CPU_AW / CPU_DW : architectural register file geometry
//   CPU_CNT_W                  : default pending-write counter width
//   CNT_MAX                    : saturation value of a default-width counter
package cpu_pkg;
  localparam int CPU_NREG  = 32;
  localparam int CPU_AW    = 5;
  localparam int CPU_DW    = 32;
  localparam int CPU_CNT_W = 2;
  localparam int CNT_MAX   = (1 << CPU_CNT_W) - 1;
endpackage

// File: rtl/sb_operand_mux.sv
// sb_operand_mux: resolves one decode source operand.
// Source order: unused port -> r0 -> youngest matching forward stage ->
// same-cycle write-back -> pending write (stall) -> regfile.
//   rd_en/rd_addr/rf_rdata : the source request and raw regfile data
//   fwd_*                  : forwarding stages, index 0 youngest
//   wb_*                   : write-back port
//   pend                   : a write to rd_addr is still in flight
//   rd_data/rd_ok          : resolved value and its validity
module sb_operand_mux #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NFWD = 2
) (
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  input  logic [DW-1:0]             rf_rdata,
  input  logic [NFWD-1:0]           fwd_valid,
  input  logic [NFWD-1:0][AW-1:0]   fwd_dest,
  input  logic [NFWD-1:0]           fwd_data_ok,
  input  logic [NFWD-1:0][DW-1:0]   fwd_data,
  input  logic                      wb_valid,
  input  logic [AW-1:0]             wb_dest,
  input  logic [DW-1:0]             wb_data,
  input  logic                      pend,
  output logic [DW-1:0]             rd_data,
  output logic                      rd_ok
);
  logic          hit;
  logic          hit_ok;
  logic [DW-1:0] hit_data;

  // Scan oldest to youngest so the lowest matching index is the last write.
  always_comb begin
    hit      = 1'b0;
    hit_ok   = 1'b0;
    hit_data = '0;
    for (int i = NFWD-1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_dest[i] == rd_addr) begin
        hit      = 1'b1;
        hit_ok   = fwd_data_ok[i];
        hit_data = fwd_data[i];
      end
    end
  end

  always_comb begin
    rd_ok   = 1'b1;
    rd_data = rf_rdata;
    if (!rd_en) begin
      rd_ok   = 1'b1;
    end else if (rd_addr == '0) begin
      rd_data = '0;
    end else if (hit) begin
      rd_ok   = hit_ok;
      rd_data = hit_data;
    end else if (wb_valid && wb_dest == rd_addr) begin
      rd_data = wb_data;
    end else if (pend) begin
      // Producer sits in a stage with no forwarding path; data is don't-care.
      rd_ok   = 1'b0;
    end
  end
endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write counters plus operand bypass.
//   clk, reset              : clock, async active-high reset
//   rd_en/rd_addr/rf_rdata  : NRD source requests and raw regfile data
//   rd_data/rd_ok           : resolved operands and per-operand ready
//   issue_*                 : instruction leaving decode; issue_ready says
//                             the destination counter has room
//   fwd_*                   : NFWD forwarding stages (0 = EX, youngest)
//   wb_*                    : retiring GPR write
//   flush                   : clear every pending count
//   sb_err                  : sticky counter-underflow flag
module rf_scoreboard import cpu_pkg::*; #(
  parameter int NREG  = CPU_NREG,
  parameter int AW    = CPU_AW,
  parameter int DW    = CPU_DW,
  parameter int NRD   = 2,
  parameter int NFWD  = 2,
  parameter int CNT_W = CPU_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRD-1:0]            rd_en,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  input  logic [NRD-1:0][DW-1:0]    rf_rdata,
  output logic [NRD-1:0][DW-1:0]    rd_data,
  output logic [NRD-1:0]            rd_ok,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [AW-1:0]             issue_dest,
  output logic                      issue_ready,
  input  logic [NFWD-1:0]           fwd_valid,
  input  logic [NFWD-1:0][AW-1:0]   fwd_dest,
  input  logic [NFWD-1:0]           fwd_data_ok,
  input  logic [NFWD-1:0][DW-1:0]   fwd_data,
  input  logic                      wb_valid,
  input  logic [AW-1:0]             wb_dest,
  input  logic [DW-1:0]             wb_data,
  input  logic                      flush,
  output logic                      sb_err
);
  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            uf;

  // A full counter can still take an issue if the same register retires
  // this cycle: inc and dec cancel.
  assign issue_ready = !((cnt[issue_dest] == '1) &&
                         !(wb_valid && wb_dest == issue_dest));

  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
      assign uf[r]  = 1'b0;
    end else begin : g_reg
      logic [CNT_W-1:0] c;
      logic             inc, dec;

      assign inc   = issue_valid && issue_we && issue_ready && issue_dest == AW'(r);
      assign dec   = wb_valid && wb_dest == AW'(r);
      assign uf[r] = dec && !inc && (c == '0) && !flush;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)                         c <= '0;
        else if (flush)                    c <= '0;
        else if (inc && !dec)              c <= c + 1'b1;
        else if (dec && !inc && c != '0)   c <= c - 1'b1;
      end

      assign cnt[r] = c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    sb_err <= 1'b0;
    else if (|uf) sb_err <= 1'b1;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic pend;
    assign pend = |cnt[rd_addr[p]];

    sb_operand_mux #(.AW(AW), .DW(DW), .NFWD(NFWD)) u_mux (
      .rd_en       (rd_en[p]),
      .rd_addr     (rd_addr[p]),
      .rf_rdata    (rf_rdata[p]),
      .fwd_valid   (fwd_valid),
      .fwd_dest    (fwd_dest),
      .fwd_data_ok (fwd_data_ok),
      .fwd_data    (fwd_data),
      .wb_valid    (wb_valid),
      .wb_dest     (wb_dest),
      .wb_data     (wb_data),
      .pend        (pend),
      .rd_data     (rd_data[p]),
      .rd_ok       (rd_ok[p])
    );
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;
  localparam int NREG = 32, AW = 5, DW = 32, NRD = 2, NFWD = 2, CNT_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [NRD-1:0]          rd_en;
  logic [NRD-1:0][AW-1:0]  rd_addr;
  logic [NRD-1:0][DW-1:0]  rf_rdata;
  logic [NRD-1:0][DW-1:0]  rd_data;
  logic [NRD-1:0]          rd_ok;
  logic                    issue_valid, issue_we;
  logic [AW-1:0]           issue_dest;
  logic                    issue_ready;
  logic [NFWD-1:0]         fwd_valid;
  logic [NFWD-1:0][AW-1:0] fwd_dest;
  logic [NFWD-1:0]         fwd_data_ok;
  logic [NFWD-1:0][DW-1:0] fwd_data;
  logic                    wb_valid;
  logic [AW-1:0]           wb_dest;
  logic [DW-1:0]           wb_data;
  logic                    flush;
  logic                    sb_err;

  rf_scoreboard #(.NREG(NREG), .AW(AW), .DW(DW), .NRD(NRD), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rf_rdata(rf_rdata),
    .rd_data(rd_data), .rd_ok(rd_ok),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dest(issue_dest),
    .issue_ready(issue_ready),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data_ok(fwd_data_ok),
    .fwd_data(fwd_data),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .flush(flush), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: count of outstanding writes per register, sticky error.
  int m_cnt [NREG];
  bit m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return !(m_cnt[issue_dest] == CMAX && !(wb_valid && wb_dest == issue_dest));
  endfunction

  function automatic bit m_inc(int r);
    return issue_valid && issue_we && m_ready() && int'(issue_dest) == r;
  endfunction

  function automatic bit m_dec(int r);
    return wb_valid && int'(wb_dest) == r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] <= 0;
      m_err <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] <= 0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (m_inc(r) && !m_dec(r)) m_cnt[r] <= m_cnt[r] + 1;
        else if (m_dec(r) && !m_inc(r)) begin
          if (m_cnt[r] == 0) m_err <= 1'b1;
          else               m_cnt[r] <= m_cnt[r] - 1;
        end
      end
    end
  end

  // Expected operand from the resolution rules; dc marks a don't-care value.
  task automatic m_port(input int p, output bit ok, output logic [DW-1:0] d, output bit dc);
    ok = 1'b1; d = rf_rdata[p]; dc = 1'b0;
    if (!rd_en[p]) return;
    if (rd_addr[p] == 0) begin d = '0; return; end
    for (int i = 0; i < NFWD; i++)
      if (fwd_valid[i] && fwd_dest[i] == rd_addr[p]) begin
        ok = fwd_data_ok[i]; d = fwd_data[i]; return;
      end
    if (wb_valid && wb_dest == rd_addr[p]) begin d = wb_data; return; end
    if (m_cnt[rd_addr[p]] != 0) begin ok = 1'b0; dc = 1'b1; end
  endtask

  task automatic check_all(input string tag);
    for (int p = 0; p < NRD; p++) begin
      bit ok, dc;
      logic [DW-1:0] d;
      m_port(p, ok, d, dc);
      chk($sformatf("%s rd_ok[%0d]", tag, p), rd_ok[p], ok);
      if (!dc) chk($sformatf("%s rd_data[%0d]", tag, p), rd_data[p], d);
    end
    chk({tag, " issue_ready"}, issue_ready, m_ready());
    chk({tag, " sb_err"}, sb_err, m_err);
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0;
    rf_rdata = {$urandom, $urandom};
    issue_valid = 0; issue_we = 0; issue_dest = '0;
    fwd_valid = '0; fwd_dest = '0; fwd_data_ok = '0;
    fwd_data = {$urandom, $urandom};
    wb_valid = 0; wb_dest = '0; wb_data = $urandom;
    flush = 0;
  endtask

  // Start a new cycle with idle inputs (call, set inputs, then settle()).
  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic settle(input string tag);
    #1;
    check_all(tag);
  endtask

  task automatic issue(input int r);
    cyc();
    issue_valid = 1; issue_we = 1; issue_dest = AW'(r);
    settle($sformatf("issue r%0d", r));
  endtask

  task automatic randomize_inputs();
    int pend_q[$];
    for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) pend_q.push_back(r);
    idle();
    rd_en = NRD'($urandom);
    for (int p = 0; p < NRD; p++) rd_addr[p] = AW'($urandom_range(0, 7));
    fwd_valid   = NFWD'($urandom);
    fwd_data_ok = NFWD'($urandom);
    for (int i = 0; i < NFWD; i++) fwd_dest[i] = AW'($urandom_range(0, 7));
    issue_valid = ($urandom_range(0, 99) < 55);
    issue_we    = ($urandom_range(0, 9) != 0);
    issue_dest  = AW'($urandom_range(0, 7));
    wb_valid    = ($urandom_range(0, 99) < 40);
    if (pend_q.size() > 0 && $urandom_range(0, 19) != 0)
      wb_dest = AW'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
    else
      wb_dest = AW'($urandom_range(0, 15));
    flush = ($urandom_range(0, 99) < 2);
  endtask

  initial begin
    idle();
    #1 reset = 1'b1;
    @(negedge clk);
    idle();
    settle("reset");
    chk("reset rd_ok", rd_ok, 2'b11);
    chk("reset issue_ready", issue_ready, 1'b1);
    chk("reset sb_err", sb_err, 1'b0);
    reset = 1'b0;

    // Idle operands read the regfile; r0 reads zero.
    cyc();
    rd_en = 2'b11; rd_addr[1] = 5; rd_addr[0] = 3;
    settle("plain read");
    chk("plain rd_ok", rd_ok, 2'b11);
    chk("plain rd_data0", rd_data[0], rf_rdata[0]);
    rd_addr = '0;
    settle("r0 read");
    chk("r0 rd_data0", rd_data[0], 0);
    chk("r0 rd_data1", rd_data[1], 0);

    // Load in EX not ready, then ready.
    issue(7);
    cyc();
    rd_en = 2'b01; rd_addr[0] = 7;
    fwd_valid = 2'b01; fwd_dest[0] = 7; fwd_data_ok = 2'b00;
    settle("fwd pending");
    chk("fwd pending rd_ok", rd_ok[0], 1'b0);
    fwd_data_ok = 2'b01; fwd_data[0] = 32'hDEADBEEF;
    settle("fwd ready");
    chk("fwd ready rd_ok", rd_ok[0], 1'b1);
    chk("fwd ready rd_data", rd_data[0], 32'hDEADBEEF);
    cyc();
    wb_valid = 1; wb_dest = 7;
    settle("wb r7");

    // Youngest forward stage wins.
    cyc();
    rd_en = 2'b01; rd_addr[0] = 4;
    fwd_valid = 2'b11; fwd_dest[0] = 4; fwd_dest[1] = 4; fwd_data_ok = 2'b11;
    fwd_data[0] = 32'h11; fwd_data[1] = 32'h22;
    settle("youngest");
    chk("youngest rd_data", rd_data[0], 32'h11);

    // Counter saturation on r9.
    issue(9); issue(9); issue(9);
    cyc();
    issue_dest = 9;
    settle("sat");
    chk("sat issue_ready", issue_ready, 1'b0);
    issue_valid = 1; issue_we = 1; wb_valid = 1; wb_dest = 9;
    settle("sat+wb");
    chk("sat+wb issue_ready", issue_ready, 1'b1);
    cyc();
    issue_dest = 9;
    settle("sat hold");
    chk("sat hold issue_ready", issue_ready, 1'b0);

    // Unexposed in-flight write on r6, then write-back bypass.
    issue(6);
    cyc();
    rd_en = 2'b01; rd_addr[0] = 6;
    settle("r6 stall");
    chk("r6 stall rd_ok", rd_ok[0], 1'b0);
    wb_valid = 1; wb_dest = 6; wb_data = 32'h55;
    settle("r6 wb");
    chk("r6 wb rd_ok", rd_ok[0], 1'b1);
    chk("r6 wb rd_data", rd_data[0], 32'h55);
    cyc();
    rd_en = 2'b01; rd_addr[0] = 6;
    settle("r6 done");
    chk("r6 done rd_ok", rd_ok[0], 1'b1);

    // Underflow, flush, async reset.
    cyc();
    wb_valid = 1; wb_dest = 12;
    settle("uf");
    cyc();
    settle("uf next");
    chk("uf sb_err", sb_err, 1'b1);
    for (int r = 1; r <= 5; r++) issue(r);
    cyc();
    flush = 1; issue_valid = 1; issue_we = 1; issue_dest = 10;
    wb_valid = 1; wb_dest = 1;
    settle("flush");
    cyc();
    rd_en = 2'b11; rd_addr[0] = 1; rd_addr[1] = 10; issue_dest = 9;
    settle("post flush");
    chk("post flush rd_ok", rd_ok, 2'b11);
    chk("post flush issue_ready", issue_ready, 1'b1);
    chk("post flush sb_err", sb_err, 1'b1);
    issue(3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("async reset sb_err", sb_err, 1'b0);
    chk("async reset issue_ready", issue_ready, 1'b1);
    @(negedge clk);
    idle();
    reset = 1'b0;
    rd_en = 2'b01; rd_addr[0] = 3;
    settle("after reset");
    chk("after reset rd_ok", rd_ok[0], 1'b1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      randomize_inputs();
      settle($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
